// File: rtl/des_decrypt_key_sched.sv
// DES decryption key schedule: PC-1 load, then K16..K1 via right-rotating C/D over valid/ready beats.
// Optional DES_KEY_PARITY_CHECK_EN rejects keys whose bytes lack odd parity.
module des_decrypt_key_sched (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [63:0] i_key,
    input  logic        i_ready,
    output logic [47:0] o_rd_key,
    output logic        o_rd_key_valid,
    output logic [3:0]  o_round,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_parity_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_DONE
    } state_t;

    // FIPS 46-3 bit numbers; bit 1 is the MSB of the source vector
    localparam int unsigned PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int unsigned i = 0; i < 56; i++) begin
            r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int unsigned i = 0; i < 48; i++) begin
            r[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
        end
        return r;
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state;
    logic [27:0] c_reg;
    logic [27:0] d_reg;
    logic [3:0]  round;
    logic        two_step;
    logic        key_ok;

    // Round 16 is held as 4'd0 so the counter wraps naturally into 15 on the first step
    always_comb begin
        two_step = 1'b1;
        if (round inside {4'd0, 4'd1, 4'd2, 4'd9}) begin
            two_step = 1'b0;
        end
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    assign key_ok = (^i_key[63:56]) & (^i_key[55:48]) & (^i_key[47:40]) & (^i_key[39:32])
                  & (^i_key[31:24]) & (^i_key[23:16]) & (^i_key[15:8])  & (^i_key[7:0]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_parity_err <= 1'b0;
        end else if (state == S_IDLE && i_start) begin
            o_parity_err <= ~key_ok;
        end
    end
`else
    assign key_ok       = 1'b1;
    assign o_parity_err = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= S_IDLE;
            c_reg          <= '0;
            d_reg          <= '0;
            round          <= '0;
            o_rd_key_valid <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start && key_ok) begin
                        {c_reg, d_reg} <= pc1(i_key);
                        round          <= 4'd0;
                        state          <= S_EMIT;
                        o_rd_key_valid <= 1'b1;
                        o_busy         <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (o_rd_key_valid && i_ready) begin
                        if (round == 4'd1) begin
                            state          <= S_DONE;
                            o_rd_key_valid <= 1'b0;
                            o_busy         <= 1'b0;
                            o_done         <= 1'b1;
                        end else begin
                            c_reg <= rotr(c_reg, two_step);
                            d_reg <= rotr(d_reg, two_step);
                            round <= round - 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    o_done <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state          <= S_IDLE;
                    o_rd_key_valid <= 1'b0;
                    o_busy         <= 1'b0;
                    o_done         <= 1'b0;
                end
            endcase
        end
    end

    assign o_rd_key = pc2({c_reg, d_reg});
    assign o_round  = round;

endmodule

// File: tb/tb_des_decrypt_key_sched.sv
// Scoreboarded bench for des_decrypt_key_sched against a forward (left-rotating) DES key schedule model.
module tb_des_decrypt_key_sched;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_start = 1'b0;
    logic [63:0] i_key = '0;
    logic        i_ready = 1'b1;
    logic [47:0] o_rd_key;
    logic        o_rd_key_valid;
    logic [3:0]  o_round;
    logic        o_busy;
    logic        o_done;
    logic        o_parity_err;

    des_decrypt_key_sched dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start        (i_start),
        .i_key          (i_key),
        .i_ready        (i_ready),
        .o_rd_key       (o_rd_key),
        .o_rd_key_valid (o_rd_key_valid),
        .o_round        (o_round),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_parity_err   (o_parity_err)
    );

    initial forever #5 i_clk = ~i_clk;

    typedef struct {
        logic [47:0] k;
        logic [3:0]  rnd;
        bit          is_done;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    bit          rand_ready = 1'b0;
    logic [47:0] fwd_k [1:16];

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Encryption-order schedule: left rotations, K1..K16
    task automatic build_forward(input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1[i])];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 1; r <= 16; r++) begin
            for (int s = 0; s < SHIFTS[r-1]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) fwd_k[r][6'(47 - i)] = cd[6'(56 - PC2[i])];
        end
    endtask

    task automatic push_expected();
        for (int r = 16; r >= 1; r--) begin
            sb.push_back('{k: fwd_k[r], rnd: (r == 16) ? 4'd0 : 4'(r), is_done: 1'b0});
        end
        sb.push_back('{k: '0, rnd: '0, is_done: 1'b1});
    endtask

    function automatic logic [63:0] fix_parity(input logic [63:0] k);
        logic [63:0] r;
        r = k;
        for (int b = 0; b < 8; b++) r[8*b] = ~(^r[8*b+1 +: 7]);
        return r;
    endfunction

    // Ready driver: changes just after the active edge
    initial forever begin
        @(posedge i_clk);
        #1;
        i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops the scoreboard on every transfer and on o_done; checks holds during stalls
    initial begin
        logic [47:0] held_k;
        logic [3:0]  held_r;
        bit          hold_pending;
        exp_t        e;
        hold_pending = 1'b0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending && o_rd_key_valid) begin
                    check("hold_key", 64'(o_rd_key), 64'(held_k));
                    check("hold_round", 64'(o_round), 64'(held_r));
                end
                hold_pending = o_rd_key_valid && !i_ready;
                held_k = o_rd_key;
                held_r = o_round;
                if (o_rd_key_valid && i_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_key: got %h round %0d expected nothing", o_rd_key, o_round);
                    end else begin
                        e = sb.pop_front();
                        check("key_not_done", 64'(e.is_done), 64'(0));
                        check("subkey", 64'(o_rd_key), 64'(e.k));
                        check("round", 64'(o_round), 64'(e.rnd));
                    end
                end
                if (o_done) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_done: got o_done=1 expected 0");
                    end else begin
                        e = sb.pop_front();
                        check("done_marker", 64'(e.is_done), 64'(1));
                        check("done_busy", 64'(o_busy), 64'(0));
                        check("done_valid", 64'(o_rd_key_valid), 64'(0));
                    end
                end
            end
        end
    end

    task automatic start_pulse(input logic [63:0] key);
        @(posedge i_clk);
        #1;
        i_key   = key;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic run_key(input logic [63:0] key, input bit known, input int inject_round);
        int cnt;
        bit injected;
        build_forward(key);
        if (known) begin
            fwd_k[16] = 48'hCB3D8B0E17F5;
            fwd_k[15] = 48'hBF918D3D3F0A;
            fwd_k[2]  = 48'h79AED9DBC9E5;
            fwd_k[1]  = 48'h1B02EFFC7072;
        end
        push_expected();
        start_pulse(key);
        @(negedge i_clk);
        cnt = 1;
        injected = 1'b0;
        check("first_valid", 64'(o_rd_key_valid), 64'(1));
        check("first_round", 64'(o_round), 64'(0));
        check("first_busy", 64'(o_busy), 64'(1));
        while (!o_done && cnt < 400) begin
            if (injected && i_start) i_start = 1'b0;
            if (inject_round != 0 && !injected && o_rd_key_valid && o_round == 4'(inject_round)) begin
                i_key    = '0;
                i_start  = 1'b1;
                injected = 1'b1;
            end
            @(negedge i_clk);
            cnt++;
        end
        i_start = 1'b0;
        if (!o_done) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no o_done after %0d cycles expected one", cnt);
            sb.delete();
        end else if (!rand_ready) begin
            check("done_cycle", 64'(cnt), 64'(17));
        end
        @(negedge i_clk);
        check("drain", 64'(sb.size()), 64'(0));
        check("idle_busy", 64'(o_busy), 64'(0));
        check("idle_done", 64'(o_done), 64'(0));
        sb.delete();
    endtask

    task automatic reset_mid_run();
        int cnt;
        build_forward(64'h133457799BBCDFF1);
        push_expected();
        start_pulse(64'h133457799BBCDFF1);
        cnt = 0;
        do begin
            @(negedge i_clk);
            cnt++;
        end while (!(o_rd_key_valid && o_round == 4'd9) && cnt < 100);
        check("reached_round9", 64'(o_round), 64'(9));
        #2;
        i_rst_n = 1'b0;
        #1;
        sb.delete();
        check("arst_valid", 64'(o_rd_key_valid), 64'(0));
        check("arst_busy", 64'(o_busy), 64'(0));
        check("arst_done", 64'(o_done), 64'(0));
        check("arst_key", 64'(o_rd_key), 64'(0));
        check("arst_round", 64'(o_round), 64'(0));
        check("arst_perr", 64'(o_parity_err), 64'(0));
        repeat (3) @(negedge i_clk);
        check("arst_no_done", 64'(o_done), 64'(0));
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        i_rst_n = 1'b0;
        #4;
        check("rst_valid", 64'(o_rd_key_valid), 64'(0));
        check("rst_busy", 64'(o_busy), 64'(0));
        check("rst_done", 64'(o_done), 64'(0));
        check("rst_key", 64'(o_rd_key), 64'(0));
        check("rst_round", 64'(o_round), 64'(0));
        check("rst_perr", 64'(o_parity_err), 64'(0));
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        rand_ready = 1'b0;
        run_key(64'h133457799BBCDFF1, 1'b1, 0);
        rand_ready = 1'b1;
        run_key(64'h133457799BBCDFF1, 1'b1, 0);
        run_key(64'h133457799BBCDFF1, 1'b1, 10);

        rand_ready = 1'b0;
        reset_mid_run();
        run_key(64'h133457799BBCDFF1, 1'b1, 0);

`ifdef DES_KEY_PARITY_CHECK_EN
        begin
            bit saw_valid;
            start_pulse(64'h133457799BBCDFF0);
            @(negedge i_clk);
            check("perr_set", 64'(o_parity_err), 64'(1));
            saw_valid = 1'b0;
            repeat (20) begin
                @(negedge i_clk);
                if (o_rd_key_valid || o_busy || o_done) saw_valid = 1'b1;
            end
            check("perr_no_emit", 64'(saw_valid), 64'(0));
            run_key(64'h133457799BBCDFF1, 1'b1, 0);
            check("perr_cleared", 64'(o_parity_err), 64'(0));
        end
`else
        run_key(64'h133457799BBCDFF0, 1'b1, 0);
        check("perr_tied_low", 64'(o_parity_err), 64'(0));
`endif

        rand_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            run_key(fix_parity({$urandom, $urandom}), 1'b0, 0);
        end
        rand_ready = 1'b0;

        repeat (2) @(negedge i_clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/des_decrypt_key_sched.md
Name: des_decrypt_key_sched

Overview:
- Sequential DES key schedule for the decryption datapath.
- Loads a 64-bit key, applies PC-1, then emits the 16 round subkeys in reverse order (K16 first, K1 last), one per accepted valid/ready beat.
- Walks C/D backwards using right rotations. It is the inverse of the forward left-rotating key round that feeds encryption.
- Sits between the key register and the decrypt round datapath.

Parameters:
- None. DES widths are fixed: key 64, C/D 28 each, subkey 48.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  load i_key and begin a schedule; honoured only in IDLE
- i_key  input  64  DES key; bit 1 (FIPS numbering) = i_key[63]; parity bits ignored unless feature enabled
- i_ready  input  1  downstream accepts o_rd_key this cycle
- o_rd_key  output  48  PC-2 subkey; FIPS bit 1 = o_rd_key[47]
- o_rd_key_valid  output  1  o_rd_key/o_round valid
- o_round  output  4  DES round index of the presented subkey, 16 down to 1 (value 0 encodes round 16)
- o_busy  output  1  schedule in progress
- o_done  output  1  one-cycle pulse after K1 accepted
- o_parity_err  output  1  key parity error (see Optional Feature)

Behaviour:
- Reset (asynchronous, i_rst_n low) clears all state, independent of i_clk:
  - state=IDLE; C, D = 0; round counter = 0.
  - o_rd_key_valid=0, o_busy=0, o_done=0, o_parity_err=0.
  - o_rd_key = PC-2 of zero = 0.
  - Reset mid-schedule abandons the run; no o_done.
- States:
  - IDLE: o_busy=0. On i_start=1 at a clock edge:
    - C <= PC-1 left half (28 bits), D <= PC-1 right half. C bit 1 = C[27].
    - round <= 16; state <= EMIT.
  - EMIT: o_busy=1, o_rd_key_valid=1.
    - o_rd_key = PC-2({C,D}), combinational from registered C/D.
  - DONE: single cycle. o_done=1, o_busy=0, o_rd_key_valid=0; next state IDLE.
- Latency: the first subkey (K16) is valid the cycle after i_start is sampled. K16 = PC-2(C0,D0), because the total rotation over 16 rounds is 28 (identity).
- Handshake in EMIT:
  - Transfer occurs when o_rd_key_valid && i_ready.
  - No transfer: C, D, round and o_rd_key are held stable.
  - On transfer with round>1:
    - C <= rotr(C, s(round)), D <= rotr(D, s(round)); round <= round-1.
    - s(r)=1 for r in {1,2,9,16}; otherwise s(r)=2.
    - rotr1(x) = {x[0], x[27:1]}; rotr2(x) = {x[1:0], x[27:2]}.
  - On transfer with round==1: state <= DONE.
- Back-to-back: with i_ready held high, the 16 subkeys occupy 16 consecutive cycles, then o_done on cycle 17.
- i_start during EMIT/DONE is ignored; i_key is not re-sampled. i_start in the same cycle DONE exits is also ignored; it is accepted from IDLE only.
- o_round is 4 bits; round 16 is encoded as 4'd0, rounds 1..15 as their values.

Optional Feature:
- Macro: DES_KEY_PARITY_CHECK_EN
- Defined:
  - On an i_start accepted in IDLE, each key byte i_key[8k+7:8k] must have odd parity.
  - If any byte fails: o_parity_err <= 1, state stays IDLE, no subkeys emitted, no o_done.
  - o_parity_err is cleared by the next i_start whose key passes, or by reset.
- Undefined: no parity logic; o_parity_err tied 0; every key is accepted.

Test Plan:
- Reset: i_rst_n=0 asserted asynchronously mid-EMIT (round 9) -> all outputs 0 immediately, state IDLE; next i_start restarts at round 16 (o_round=0).
- Key 0x133457799BBCDFF1, i_start, i_ready=1 -> cycle+1: o_rd_key=0xCB3D8B0E17F5 (K16); next 0xBF918D3D3F0A (K15); ... 0x79AED9DBC9E5 (K2); 0x1B02EFFC7072 (K1); then o_done pulse; o_busy low.
- Same key with i_ready toggled pseudo-randomly -> identical 16-key sequence; o_rd_key/o_round stable while i_ready=0; no skips or duplicates.
- i_start pulsed with key 0x0 during round 10 -> ignored; sequence for 0x133457799BBCDFF1 continues unchanged.
- Cross-check: for 20 random keys, the reversed output sequence must equal the forward left-rotating schedule model, K1..K16.
- DES_KEY_PARITY_CHECK_EN defined: key 0x133457799BBCDFF0 -> o_parity_err=1, o_rd_key_valid stays 0; then key 0x133457799BBCDFF1 -> o_parity_err=0, normal sequence.
